// File: rtl/mips_bus_mem_unit.sv
// Avalon-MM master front-end for the multicycle MIPS core: one port shared by fetch, load and
// store. Aligns requests onto bus lanes, holds them across waitrequest and extends load data.
module mips_bus_mem_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  input  logic                  waitrequest,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     readdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrAlign   = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e           state_q;
  logic             write_q;
  logic             signed_q;
  logic [1:0]       size_q;
  logic [LSB-1:0]   lane_q;
  logic [31:0]      wait_cnt_q;

  // Request decode, evaluated on the live req_* inputs during IDLE.
  logic [LSB-1:0]   req_lane;
  logic [2:0]       align_mask;
  logic [BYTES-1:0] be_base;
  logic             size_ok;
  logic             aligned;

  assign req_lane = req_addr[LSB-1:0];

  always_comb begin
    size_ok    = 1'b1;
    align_mask = 3'b000;
    be_base    = BYTES'(1);
    unique case (req_size)
      2'd0: begin
        align_mask = 3'b000;
        be_base    = BYTES'(1);
      end
      2'd1: begin
        align_mask = 3'b001;
        be_base    = BYTES'(2'b11);
      end
      2'd2: begin
        align_mask = 3'b011;
        be_base    = BYTES'(4'hF);
      end
      2'd3: begin
        size_ok    = (DATA_W == 64);
        align_mask = 3'b111;
        be_base    = '1;
      end
    endcase
  end

  assign aligned = (req_addr[2:0] & align_mask) == 3'b000;

  // Load extraction: shift the addressed lane down, then fill above the access MSB.
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic [IDX_W-1:0]  msb;
  logic              fill;

  always_comb begin
    shifted = readdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    msb = IDX_W'(7);
      2'd1:    msb = IDX_W'(15);
      2'd2:    msb = IDX_W'(31);
      default: msb = IDX_W'(DATA_W - 1);
    endcase
    fill     = signed_q & shifted[msb];
    load_ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i > int'(msb)) ? fill : shifted[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ErrNone;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      wait_cnt_q <= '0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'd0;
      lane_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q    <= req_write;
            signed_q   <= req_signed;
            size_q     <= req_size;
            lane_q     <= req_lane;
            req_ready  <= 1'b0;
            wait_cnt_q <= '0;
            if (size_ok && aligned) begin
              state_q    <= StBus;
              read       <= !req_write;
              write      <= req_write;
              address    <= req_addr & ~ADDR_W'(BYTES - 1);
              writedata  <= req_wdata << {req_lane, 3'b000};
              byteenable <= be_base << req_lane;
            end else begin
              // Illegal request: answer straight away without touching the bus.
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= ErrAlign;
              resp_rdata <= '0;
            end
          end
        end
        StBus: begin
          if (!waitrequest) begin
            state_q    <= StResp;
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= ErrNone;
            resp_rdata <= write_q ? '0 : load_ext;
          end else if (TIMEOUT != 0 && wait_cnt_q == 32'(TIMEOUT - 1)) begin
            state_q    <= StResp;
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= ErrTimeout;
            resp_rdata <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end
        StResp: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_mem_unit.sv
// Bench for mips_bus_mem_unit (32-bit bus, TIMEOUT=4): directed table, random accesses checked
// against an arithmetic reference model, and a reset-during-bus sequence.
module tb_mips_bus_mem_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] address;
  logic        read, write, waitrequest;
  logic [31:0] writedata, readdata;
  logic [3:0]  byteenable;

  mips_bus_mem_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          nwait;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [31:0] baddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
  } vec_t;

  typedef struct {
    logic        got;
    int          lat;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        stable;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        idle_after;
  } obs_t;

  int n_checks = 0;
  int n_err    = 0;
  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: derives every expected field from the access rules with plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     nbytes;
    int     lane;
    longint full;
    longint val;
    r      = v;
    nbytes = 1 << v.sz;
    lane   = int'(v.addr % 4);
    r.rdata = 32'd0;
    if (v.sz == 2'd3 || (v.addr % nbytes) != 0) begin
      r.err = 2'd1; r.lat = 2; r.baddr = 32'd0; r.be = 4'd0; r.wdata = 32'd0;
      return r;
    end
    r.baddr = v.addr - 32'(lane);
    r.be    = 4'(((1 << nbytes) - 1) << lane);
    r.wdata = v.wd << (8 * lane);
    if (v.nwait + 1 > int'(TO)) begin
      r.err = 2'd2; r.lat = 2 + int'(TO);
    end else begin
      r.err = 2'd0; r.lat = 3 + v.nwait;
    end
    if (!v.wr && r.err == 2'd0) begin
      full = longint'(1) << (8 * nbytes);
      val  = (longint'(v.rd) >> (8 * lane)) % full;
      if (v.sgn && val >= full / 2) val = val - full;
      r.rdata = 32'(val);
    end
    return r;
  endfunction

  // Drives one request from a negedge with the unit idle and plays the Avalon slave.
  task automatic run(input vec_t v, output obs_t o);
    int bus;
    bus = 0;
    o.got = 1'b0; o.lat = 0; o.rd_cyc = 0; o.wr_cyc = 0; o.addr = '0; o.wd = '0; o.be = '0;
    o.stable = 1'b1; o.rdata = '0; o.err = '0; o.idle_after = 1'b0;
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wd; readdata = v.rd;
    for (int k = 2; k <= 40 && !o.got; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (read || write) begin
        bus++;
        if (bus == 1) begin
          o.addr = address; o.be = byteenable; o.wd = writedata;
        end else if (address !== o.addr || byteenable !== o.be || writedata !== o.wd) begin
          o.stable = 1'b0;
        end
        if (read) o.rd_cyc++;
        if (write) o.wr_cyc++;
        waitrequest = (bus <= v.nwait);
      end else begin
        waitrequest = 1'b0;
      end
      if (resp_valid) begin
        o.got = 1'b1; o.lat = k; o.rdata = resp_rdata; o.err = resp_err;
      end
    end
    waitrequest = 1'b0;
    @(negedge clk);
    o.idle_after = !resp_valid && req_ready;
  endtask

  task automatic apply(input string tag, input vec_t v);
    obs_t o;
    int   bus;
    run(v, o);
    bus = (v.err == 2'd1) ? 0 : v.lat - 2;
    check({tag, " resp_seen"}, 32'(o.got), 32'd1);
    check({tag, " latency"}, 32'(o.lat), 32'(v.lat));
    check({tag, " resp_err"}, 32'(o.err), 32'(v.err));
    check({tag, " resp_rdata"}, o.rdata, v.rdata);
    check({tag, " read_cycles"}, 32'(o.rd_cyc), v.wr ? 32'd0 : 32'(bus));
    check({tag, " write_cycles"}, 32'(o.wr_cyc), v.wr ? 32'(bus) : 32'd0);
    check({tag, " idle_after"}, 32'(o.idle_after), 32'd1);
    if (bus > 0) begin
      check({tag, " address"}, o.addr, v.baddr);
      check({tag, " byteenable"}, 32'(o.be), 32'(v.be));
      check({tag, " writedata"}, o.wd, v.wdata);
      check({tag, " stable"}, 32'(o.stable), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   seen;
    // wr sz sgn addr wd rd nwait | err rdata baddr wdata be lat
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80AABBCC, 0,
                2'd0, 32'hFFFFFF80, 32'h100, 32'h0, 4'b1000, 3};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 32'h0, 0,
                2'd0, 32'h0, 32'h100, 32'h12340000, 4'b1100, 3};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hDEADBEEF, 3,
                2'd0, 32'hDEADBEEF, 32'h200, 32'h0, 4'b1111, 6};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h202, 32'h0, 32'h11111111, 0,
                2'd1, 32'h0, 32'h0, 32'h0, 4'b0000, 2};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h22222222, 0,
                2'd1, 32'h0, 32'h0, 32'h0, 4'b0000, 2};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h12345678, 100,
                2'd2, 32'h0, 32'h300, 32'h0, 4'b1111, 6};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80010000, 0,
                2'd0, 32'h00008001, 32'h100, 32'h0, 4'b1100, 3};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80010000, 0,
                2'd0, 32'hFFFF8001, 32'h100, 32'h0, 4'b1100, 3};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h12345678, 0,
                2'd0, 32'h00000056, 32'h100, 32'h0, 4'b0010, 3};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h7, 32'h000000AB, 32'h0, 2,
                2'd0, 32'h0, 32'h4, 32'hAB000000, 4'b1000, 5};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 32'h33333333, 0,
                2'd1, 32'h0, 32'h0, 32'h0, 4'b0000, 2};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0, 1,
                2'd0, 32'h0, 32'h10, 32'hCAFEF00D, 4'b1111, 4};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 32'h0000007F, 0,
                2'd0, 32'h0000007F, 32'h100, 32'h0, 4'b0001, 3};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h1234F00D, 0,
                2'd0, 32'hFFFFF00D, 32'h100, 32'h0, 4'b0011, 3};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h44444444, 4,
                2'd2, 32'h0, 32'h40, 32'h0, 4'b1111, 6};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset read_write", {30'd0, read, write}, 32'd0);
    check("reset address", address, 32'd0);
    check("reset writedata", writedata, 32'd0);
    check("reset byteenable", 32'(byteenable), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) apply($sformatf("t%0d", i), tbl[i]);

    for (int i = 0; i < 80; i++) begin
      v.wr   = 1'($urandom_range(0, 1));
      v.sz   = 2'($urandom_range(0, 3));
      v.sgn  = 1'($urandom_range(0, 1));
      v.addr = $urandom & 32'h0000FFFF;
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'd1 << v.sz) - 32'd1);
      v.wd    = $urandom;
      v.rd    = $urandom;
      v.nwait = int'($urandom_range(0, 5));
      apply($sformatf("r%0d", i), model(v));
    end

    // Reset while a read is stalled on the bus.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h400; readdata = 32'h55555555; waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid read_before", 32'(read), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid read_after", 32'(read), 32'd0);
    check("rst_mid req_ready", 32'(req_ready), 32'd1);
    check("rst_mid resp_valid", 32'(resp_valid), 32'd0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("rst_mid no_resp", 32'(seen), 32'd0);
    waitrequest = 1'b0;
    apply("rst_mid recover", tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
